// File: rtl/snake_pkg.sv
// Shared encodings and grid geometry for the snake game datapath.
// Imported by the segment store, its comparator and the bus interface users.
package snake_pkg;

    typedef enum logic [1:0] {
        GS_RESTART = 2'b00,
        GS_START   = 2'b01,
        GS_PLAY    = 2'b10,
        GS_DIE     = 2'b11
    } game_status_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        PIX_NONE = 2'b00,
        PIX_HEAD = 2'b01,
        PIX_BODY = 2'b10,
        PIX_WALL = 2'b11
    } pixel_e;

    localparam int GRID_W     = 40;
    localparam int GRID_H     = 30;
    localparam int CELL_SHIFT = 4;

    // Opposite directions differ only in bit 0 (up/down, left/right).
    function automatic logic is_reverse(input dir_e a, input dir_e b);
        return (2'(a) ^ 2'(b)) == 2'b01;
    endfunction

    // Coordinates are 7 bits wide so an off-grid step lands on or past a wall.
    function automatic logic is_wall(input logic [6:0] cx, input logic [6:0] cy);
        return (cx == 7'd0) || (cx >= 7'(GRID_W - 1)) ||
               (cy == 7'd0) || (cy >= 7'(GRID_H - 1));
    endfunction

endpackage

// File: rtl/snake_body_if.sv
// Control and pixel-query bus between the game controller / display and snake_body.
// The master drives game control and pixel coordinates; the slave returns pixel class and state.
interface snake_body_if;

    logic       move_tick;
    logic [1:0] dir;
    logic       grow;
    logic [1:0] game_status;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [1:0] snake;
    logic [5:0] head_x;
    logic [4:0] head_y;
    logic [4:0] length;
    logic       hit_wall;
    logic       hit_self;

    modport master (
        output move_tick, dir, grow, game_status, x_pos, y_pos,
        input  snake, head_x, head_y, length, hit_wall, hit_self
    );

    modport slave (
        input  move_tick, dir, grow, game_status, x_pos, y_pos,
        output snake, head_x, head_y, length, hit_wall, hit_self
    );

endinterface

// File: rtl/snake_cell_match.sv
// Combinational comparison of one grid cell against the segment array.
// Reports a hit on the head slot and, separately, on any valid body slot.
module snake_cell_match #(
    parameter int MAX_LEN = 16
) (
    input  logic [5:0]                 cell_x_i,
    input  logic [5:0]                 cell_y_i,
    input  logic [MAX_LEN-1:0][5:0]    seg_x_i,
    input  logic [MAX_LEN-1:0][4:0]    seg_y_i,
    input  logic [MAX_LEN-1:0]         valid_i,
    output logic                       head_hit_o,
    output logic                       body_hit_o
);

    always_comb begin
        head_hit_o = valid_i[0] && (seg_x_i[0] == cell_x_i) && ({1'b0, seg_y_i[0]} == cell_y_i);
        body_hit_o = 1'b0;
        for (int i = 1; i < MAX_LEN; i++) begin
            if (valid_i[i] && (seg_x_i[i] == cell_x_i) && ({1'b0, seg_y_i[i]} == cell_y_i)) begin
                body_hit_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_body.sv
// Snake segment store: advances head/body on move ticks, detects wall/self hits,
// and classifies the queried display pixel with one cycle of latency.
module snake_body
    import snake_pkg::*;
#(
    parameter int MAX_LEN   = 16,
    parameter int START_LEN = 3,
    parameter int START_X   = 20,
    parameter int START_Y   = 15
) (
    input logic         clk,
    input logic         rst,
    snake_body_if.slave bus
);

    localparam logic [4:0] MAX_LEN_W = 5'(MAX_LEN);

    logic [MAX_LEN-1:0][5:0] seg_x_q, seg_x_d;
    logic [MAX_LEN-1:0][4:0] seg_y_q, seg_y_d;
    logic [4:0]              length_q, length_d;
    dir_e                    dir_q, dir_d;
    logic                    grow_pend_q, grow_pend_d;
    logic                    hit_wall_q, hit_wall_d;
    logic                    hit_self_q, hit_self_d;
    pixel_e                  snake_q, snake_d;

    logic                    restart, move_en, grow_pend_eff, grow_now;
    dir_e                    dir_req, dir_res;
    logic [6:0]              cand_x, cand_y;
    logic                    cand_wall;
    logic [MAX_LEN-1:0]      seg_valid, self_valid;
    logic [5:0]              query_x, query_y;
    logic                    query_wall, query_head, query_body;
    logic                    self_head, self_body;

    assign restart       = (game_status_e'(bus.game_status) == GS_RESTART);
    assign move_en       = bus.move_tick && (game_status_e'(bus.game_status) == GS_PLAY);
    assign dir_req       = dir_e'(bus.dir);
    assign dir_res       = is_reverse(dir_req, dir_q) ? dir_q : dir_req;
    assign grow_pend_eff = grow_pend_q | bus.grow;
    assign grow_now      = grow_pend_eff && (length_q < MAX_LEN_W);

    always_comb begin
        cand_x = {1'b0, seg_x_q[0]};
        cand_y = {2'b00, seg_y_q[0]};
        case (dir_res)
            DIR_UP:    cand_y = cand_y - 7'd1;
            DIR_DOWN:  cand_y = cand_y + 7'd1;
            DIR_LEFT:  cand_x = cand_x - 7'd1;
            default:   cand_x = cand_x + 7'd1;
        endcase
    end

    assign cand_wall = is_wall(cand_x, cand_y);

    // The tail cell is vacated by a non-growing move, so it is excluded from the self check.
    always_comb begin
        seg_valid  = '0;
        self_valid = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            seg_valid[i]  = (i < int'(length_q));
            self_valid[i] = grow_now ? (i < int'(length_q)) : (i + 1 < int'(length_q));
        end
    end

    assign query_x    = bus.x_pos[9:CELL_SHIFT];
    assign query_y    = bus.y_pos[9:CELL_SHIFT];
    assign query_wall = is_wall({1'b0, query_x}, {1'b0, query_y});

    snake_cell_match #(.MAX_LEN(MAX_LEN)) u_query_match (
        .cell_x_i   (query_x),
        .cell_y_i   (query_y),
        .seg_x_i    (seg_x_q),
        .seg_y_i    (seg_y_q),
        .valid_i    (seg_valid),
        .head_hit_o (query_head),
        .body_hit_o (query_body)
    );

    snake_cell_match #(.MAX_LEN(MAX_LEN)) u_self_match (
        .cell_x_i   (cand_x[5:0]),
        .cell_y_i   (cand_y[5:0]),
        .seg_x_i    (seg_x_q),
        .seg_y_i    (seg_y_q),
        .valid_i    (self_valid),
        .head_hit_o (self_head),
        .body_hit_o (self_body)
    );

    // NOTE: every signal gets its default first so no path through this block infers a latch.
    always_comb begin
        seg_x_d     = seg_x_q;
        seg_y_d     = seg_y_q;
        length_d    = length_q;
        dir_d       = dir_q;
        grow_pend_d = grow_pend_eff;
        hit_wall_d  = 1'b0;
        hit_self_d  = 1'b0;

        if (query_wall)      snake_d = PIX_WALL;
        else if (query_head) snake_d = PIX_HEAD;
        else if (query_body) snake_d = PIX_BODY;
        else                 snake_d = PIX_NONE;

        if (restart) begin
            for (int i = 0; i < START_LEN; i++) begin
                seg_x_d[i] = 6'(START_X - i);
                seg_y_d[i] = 5'(START_Y);
            end
            length_d    = 5'(START_LEN);
            dir_d       = DIR_RIGHT;
            grow_pend_d = 1'b0;
            snake_d     = PIX_NONE;
        end else if (move_en) begin
            dir_d = dir_res;
            if (cand_wall) begin
                hit_wall_d = 1'b1;
            end else if (self_head || self_body) begin
                hit_self_d = 1'b1;
            end else begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_d[i] = seg_x_q[i-1];
                    seg_y_d[i] = seg_y_q[i-1];
                end
                seg_x_d[0]  = cand_x[5:0];
                seg_y_d[0]  = cand_y[4:0];
                if (grow_now) length_d = length_q + 5'd1;
                grow_pend_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the starting segments are loaded; slots at or beyond length are masked off.
            for (int i = 0; i < START_LEN; i++) begin
                seg_x_q[i] <= 6'(START_X - i);
                seg_y_q[i] <= 5'(START_Y);
            end
            length_q    <= 5'(START_LEN);
            dir_q       <= DIR_RIGHT;
            grow_pend_q <= 1'b0;
            hit_wall_q  <= 1'b0;
            hit_self_q  <= 1'b0;
            snake_q     <= PIX_NONE;
        end else begin
            seg_x_q     <= seg_x_d;
            seg_y_q     <= seg_y_d;
            length_q    <= length_d;
            dir_q       <= dir_d;
            grow_pend_q <= grow_pend_d;
            hit_wall_q  <= hit_wall_d;
            hit_self_q  <= hit_self_d;
            snake_q     <= snake_d;
        end
    end

    assign bus.snake    = 2'(snake_q);
    assign bus.head_x   = seg_x_q[0];
    assign bus.head_y   = seg_y_q[0];
    assign bus.length   = length_q;
    assign bus.hit_wall = hit_wall_q;
    assign bus.hit_self = hit_self_q;

endmodule

// File: tb/tb_snake_body.sv
// Directed bench for snake_body: pixel queries, movement, growth, reversal,
// wall/self collision, status gating and restart, against hand-computed values.
module tb_snake_body;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    snake_body_if bus_if ();

    snake_body #(
        .MAX_LEN   (16),
        .START_LEN (3),
        .START_X   (20),
        .START_Y   (15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_move(input logic [1:0] d, input logic g);
        bus_if.dir       = d;
        bus_if.grow      = g;
        bus_if.move_tick = 1'b1;
        cycle();
        bus_if.move_tick = 1'b0;
        bus_if.grow      = 1'b0;
    endtask

    task automatic query(input int x, input int y);
        bus_if.x_pos = 10'(x);
        bus_if.y_pos = 10'(y);
        cycle();
    endtask

    task automatic restart_game();
        bus_if.game_status = 2'b00;
        cycle();
        bus_if.game_status = 2'b10;
    endtask

    initial begin
        rst                = 1'b1;
        bus_if.move_tick   = 1'b0;
        bus_if.dir         = 2'b11;
        bus_if.grow        = 1'b0;
        bus_if.game_status = 2'b01;
        bus_if.x_pos       = 10'd330;
        bus_if.y_pos       = 10'd250;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("reset_snake",    16'(bus_if.snake),    16'd0);
        check("reset_hit_wall", 16'(bus_if.hit_wall), 16'd0);
        check("reset_hit_self", 16'(bus_if.hit_self), 16'd0);
        check("reset_head_x",   16'(bus_if.head_x),   16'd20);
        check("reset_head_y",   16'(bus_if.head_y),   16'd15);
        check("reset_length",   16'(bus_if.length),   16'd3);

        query(330, 250);
        check("pix_head", 16'(bus_if.snake), 16'd1);
        query(310, 250);
        check("pix_body", 16'(bus_if.snake), 16'd2);
        query(100, 100);
        check("pix_none", 16'(bus_if.snake), 16'd0);
        query(5, 5);
        check("pix_wall", 16'(bus_if.snake), 16'd3);

        // Three moves right, then a reverse request that must be ignored.
        bus_if.game_status = 2'b10;
        repeat (3) do_move(2'b11, 1'b0);
        check("move3_head_x", 16'(bus_if.head_x), 16'd23);
        check("move3_head_y", 16'(bus_if.head_y), 16'd15);
        check("move3_length", 16'(bus_if.length), 16'd3);
        do_move(2'b10, 1'b0);
        check("reverse_head_x", 16'(bus_if.head_x), 16'd24);

        do_move(2'b11, 1'b1);
        check("grow_length", 16'(bus_if.length), 16'd4);
        check("grow_head_x", 16'(bus_if.head_x), 16'd25);

        // Length 4 loops into the cell its tail is vacating.
        do_move(2'b01, 1'b0);
        do_move(2'b10, 1'b0);
        do_move(2'b00, 1'b0);
        check("tail_head_x",   16'(bus_if.head_x),   16'd24);
        check("tail_head_y",   16'(bus_if.head_y),   16'd15);
        check("tail_hit_self", 16'(bus_if.hit_self), 16'd0);
        check("tail_length",   16'(bus_if.length),   16'd4);

        // Restart mid-game, then build length 5 and turn into the body.
        restart_game();
        check("restart_head_x", 16'(bus_if.head_x), 16'd20);
        check("restart_length", 16'(bus_if.length), 16'd3);
        do_move(2'b11, 1'b1);
        do_move(2'b11, 1'b1);
        check("self_len5", 16'(bus_if.length), 16'd5);
        do_move(2'b01, 1'b0);
        do_move(2'b10, 1'b0);
        do_move(2'b00, 1'b0);
        check("self_hit",    16'(bus_if.hit_self), 16'd1);
        check("self_wall0",  16'(bus_if.hit_wall), 16'd0);
        check("self_head_x", 16'(bus_if.head_x),   16'd21);
        check("self_head_y", 16'(bus_if.head_y),   16'd16);
        check("self_length", 16'(bus_if.length),   16'd5);
        query(352, 240);
        check("self_pulse_end", 16'(bus_if.hit_self), 16'd0);
        check("self_pix_body",  16'(bus_if.snake),    16'd2);
        query(336, 256);
        check("self_pix_head",  16'(bus_if.snake),    16'd1);

        // Twenty growing moves saturate the length at capacity.
        restart_game();
        repeat (16) do_move(2'b11, 1'b1);
        repeat (4) do_move(2'b01, 1'b1);
        check("sat_length", 16'(bus_if.length), 16'd16);
        check("sat_head_x", 16'(bus_if.head_x), 16'd36);
        check("sat_head_y", 16'(bus_if.head_y), 16'd19);

        // Drive to column 38, then into the right wall.
        restart_game();
        check("restart2_length", 16'(bus_if.length), 16'd3);
        repeat (18) do_move(2'b11, 1'b0);
        check("wall_pre_x", 16'(bus_if.head_x), 16'd38);
        do_move(2'b11, 1'b0);
        check("wall_hit",    16'(bus_if.hit_wall), 16'd1);
        check("wall_self0",  16'(bus_if.hit_self), 16'd0);
        check("wall_head_x", 16'(bus_if.head_x),   16'd38);
        check("wall_head_y", 16'(bus_if.head_y),   16'd15);
        cycle();
        check("wall_pulse_end", 16'(bus_if.hit_wall), 16'd0);
        do_move(2'b11, 1'b0);
        check("wall_frozen_x", 16'(bus_if.head_x), 16'd38);
        query(592, 240);
        check("wall_pix_body", 16'(bus_if.snake), 16'd2);

        // Ticks outside PLAY are ignored; queries still answer in DIE.
        bus_if.game_status = 2'b11;
        bus_if.x_pos = 10'd608;
        bus_if.y_pos = 10'd240;
        do_move(2'b01, 1'b0);
        check("die_head_y",   16'(bus_if.head_y), 16'd15);
        check("die_head_x",   16'(bus_if.head_x), 16'd38);
        check("die_pix_head", 16'(bus_if.snake),  16'd1);
        bus_if.game_status = 2'b01;
        do_move(2'b01, 1'b0);
        check("start_head_y", 16'(bus_if.head_y), 16'd15);

        // A tick during RESTART is ignored and the query stage is cleared.
        bus_if.game_status = 2'b00;
        bus_if.x_pos = 10'd5;
        bus_if.y_pos = 10'd5;
        do_move(2'b01, 1'b0);
        check("rs_head_x", 16'(bus_if.head_x), 16'd20);
        check("rs_head_y", 16'(bus_if.head_y), 16'd15);
        check("rs_length", 16'(bus_if.length), 16'd3);
        check("rs_snake",  16'(bus_if.snake),  16'd0);
        bus_if.game_status = 2'b10;
        do_move(2'b10, 1'b0);
        check("rs_dir_right", 16'(bus_if.head_x), 16'd21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
